dso_capture_core: RTL and testbench

//  Digital-oscilloscope acquisition core. Decimates 8-bit ADC samples, edge-triggers, captures a
//  pre/post-trigger record into a 1024x8 RAM for the HDMI wave renderer, and measures freq/Vpp.

---
 rtl/dso_pkg.sv | 19 +
 rtl/dso_meas.sv | 96 +++++++++
 rtl/dso_capture_core.sv | 139 +++++++++++++
 tb/tb_dso_capture_core.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/dso_pkg.sv
// Shared widths, FSM state type and threshold helper for the oscilloscope capture core.
package dso_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 10;
  localparam int FREQ_W = 20;

  typedef enum logic [1:0] {PRE_FILL, ARMED, POST, DONE} state_e;

  // Threshold arithmetic saturated to the unsigned sample range.
  function automatic logic [DATA_W-1:0] clamp_sample(input int value);
    if (value < 0) begin
      return '0;
    end else if (value > (2 ** DATA_W) - 1) begin
      return '1;
    end else begin
      return value[DATA_W-1:0];
    end
  endfunction
endpackage

// File: rtl/dso_meas.sv
// Per-window signal measurement: hysteretic comparator, rising-edge counter,
// running max/min and clipping flag, latched once per gate window.
module dso_meas
  import dso_pkg::*;
#(
  parameter int GATE_CYCLES = 50_000_000,
  parameter int HYST        = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample_i,
  input  logic [DATA_W-1:0] level_i,
  output logic              pulse_o,
  output logic              outrange_o,
  output logic [FREQ_W-1:0] freq_o,
  output logic [DATA_W-1:0] max_o,
  output logic [DATA_W-1:0] min_o,
  output logic [DATA_W-1:0] vpp_o
);
  localparam int GATE_W = $clog2(GATE_CYCLES + 1);

  logic [GATE_W-1:0] gate_q, gate_d;
  logic              pulse_q, pulse_d;
  logic [DATA_W-1:0] hi_thr, lo_thr;
  logic [DATA_W-1:0] run_max_q, run_max_d, run_min_q, run_min_d;
  logic [FREQ_W-1:0] run_cnt_q, run_cnt_d;
  logic              run_clip_q, run_clip_d;
  logic              gate_wrap, rise, clip;
  logic              outrange_q;
  logic [FREQ_W-1:0] freq_q;
  logic [DATA_W-1:0] max_q, min_q, vpp_q;

  always_comb begin
    hi_thr  = clamp_sample(int'(level_i) + HYST);
    lo_thr  = clamp_sample(int'(level_i) - HYST);
    pulse_d = pulse_q;
    if (sample_i >= hi_thr) begin
      pulse_d = 1'b1;
    end else if (sample_i < lo_thr) begin
      pulse_d = 1'b0;
    end
    rise      = pulse_d & ~pulse_q;
    clip      = (sample_i == '0) || (sample_i == '1);
    gate_wrap = (gate_q == GATE_W'(GATE_CYCLES - 1));
    gate_d    = gate_wrap ? '0 : gate_q + GATE_W'(1);
    // The sample arriving in the wrap clk seeds the next window.
    if (gate_wrap) begin
      run_max_d  = sample_i;
      run_min_d  = sample_i;
      run_cnt_d  = FREQ_W'(rise);
      run_clip_d = clip;
    end else begin
      run_max_d  = (sample_i > run_max_q) ? sample_i : run_max_q;
      run_min_d  = (sample_i < run_min_q) ? sample_i : run_min_q;
      run_cnt_d  = (rise && (run_cnt_q != '1)) ? run_cnt_q + FREQ_W'(1) : run_cnt_q;
      run_clip_d = run_clip_q | clip;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gate_q     <= '0;
      pulse_q    <= 1'b0;
      run_max_q  <= '0;
      run_min_q  <= '1;
      run_cnt_q  <= '0;
      run_clip_q <= 1'b0;
      outrange_q <= 1'b0;
      freq_q     <= '0;
      max_q      <= '0;
      min_q      <= '0;
      vpp_q      <= '0;
    end else begin
      gate_q     <= gate_d;
      pulse_q    <= pulse_d;
      run_max_q  <= run_max_d;
      run_min_q  <= run_min_d;
      run_cnt_q  <= run_cnt_d;
      run_clip_q <= run_clip_d;
      if (gate_wrap) begin
        outrange_q <= run_clip_q;
        freq_q     <= run_cnt_q;
        max_q      <= run_max_q;
        min_q      <= run_min_q;
        vpp_q      <= (run_max_q >= run_min_q) ? run_max_q - run_min_q : '0;
      end
    end
  end

  assign pulse_o    = pulse_q;
  assign outrange_o = outrange_q;
  assign freq_o     = freq_q;
  assign max_o      = max_q;
  assign min_o      = min_q;
  assign vpp_o      = vpp_q;
endmodule

// File: rtl/dso_capture_core.sv
// Oscilloscope acquisition core: decimation, edge trigger with auto-timeout,
// pre/post-trigger capture into block RAM, windowed read-out and measurement.
module dso_capture_core
  import dso_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int PRE_TRIG    = 150,
  parameter int GATE_CYCLES = 50_000_000,
  parameter int AUTO_TO     = 1_000_000,
  parameter int HYST        = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] ad_data,
  input  logic              wave_run,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_edge,
  input  logic [ADDR_W-1:0] h_shift,
  input  logic [ADDR_W-1:0] deci_rate,
  input  logic              ram_rd_en,
  input  logic              ram_rd_over,
  input  logic [ADDR_W-1:0] wave_rd_addr,
  output logic [DATA_W-1:0] wave_rd_data,
  output logic              outrange,
  output logic              ad_pulse,
  output logic [FREQ_W-1:0] ad_freq,
  output logic [DATA_W-1:0] ad_vpp,
  output logic [DATA_W-1:0] ad_max,
  output logic [DATA_W-1:0] ad_min
);
  localparam int CNT_W = $clog2(AUTO_TO + DEPTH + 1);

  logic [DATA_W-1:0] s0_q, s1_q;
  logic [ADDR_W-1:0] dec_cnt_q, dec_cnt_d, dec_rate_q, dec_rate_d, rate_eff;
  logic              kept, dec_wrap, trig_hit, wr_en;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  samp_q, samp_d;
  logic [ADDR_W-1:0] wr_ptr_q, trig_addr_q, trig_addr_d, rd_addr;
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  // New decimation ratio is adopted only when the current count wraps.
  always_comb begin
    rate_eff   = (deci_rate > ADDR_W'(1)) ? deci_rate : ADDR_W'(1);
    kept       = (dec_cnt_q == '0);
    dec_wrap   = (dec_cnt_q >= dec_rate_q - ADDR_W'(1));
    dec_cnt_d  = dec_wrap ? '0 : dec_cnt_q + ADDR_W'(1);
    dec_rate_d = dec_wrap ? rate_eff : dec_rate_q;
    trig_hit   = trig_edge ? ((s1_q >= trig_level) && (s0_q < trig_level))
                           : ((s1_q < trig_level) && (s0_q >= trig_level));
    wr_en      = kept && (state_q != DONE);
    rd_addr    = trig_addr_q - ADDR_W'(PRE_TRIG) + h_shift + wave_rd_addr;
  end

  always_comb begin
    state_d     = state_q;
    samp_d      = samp_q;
    trig_addr_d = trig_addr_q;
    unique case (state_q)
      PRE_FILL: if (kept) begin
        if (samp_q == CNT_W'(PRE_TRIG - 1)) begin
          state_d = ARMED;
          samp_d  = '0;
        end else begin
          samp_d = samp_q + CNT_W'(1);
        end
      end
      // Forced trigger is the first kept sample after AUTO_TO quiet ones.
      ARMED: if (kept) begin
        if (trig_hit || (samp_q == CNT_W'(AUTO_TO))) begin
          state_d     = POST;
          trig_addr_d = wr_ptr_q;
          samp_d      = CNT_W'(1);
        end else begin
          samp_d = samp_q + CNT_W'(1);
        end
      end
      POST: if (kept) begin
        if (samp_q == CNT_W'(DEPTH - PRE_TRIG - 1)) begin
          state_d = DONE;
          samp_d  = '0;
        end else begin
          samp_d = samp_q + CNT_W'(1);
        end
      end
      DONE: if (ram_rd_over && wave_run) begin
        state_d = PRE_FILL;
        samp_d  = '0;
      end
      default: state_d = PRE_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_q        <= '0;
      s1_q        <= '0;
      dec_cnt_q   <= '0;
      dec_rate_q  <= ADDR_W'(1);
      state_q     <= PRE_FILL;
      samp_q      <= '0;
      wr_ptr_q    <= '0;
      trig_addr_q <= '0;
      rd_data_q   <= '0;
    end else begin
      s0_q        <= ad_data;
      dec_cnt_q   <= dec_cnt_d;
      dec_rate_q  <= dec_rate_d;
      state_q     <= state_d;
      samp_q      <= samp_d;
      trig_addr_q <= trig_addr_d;
      if (kept) s1_q <= s0_q;
      if (wr_en) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      if (ram_rd_en) rd_data_q <= mem_q[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= s0_q;
  end

  assign wave_rd_data = rd_data_q;

  dso_meas #(
    .GATE_CYCLES(GATE_CYCLES),
    .HYST       (HYST)
  ) u_meas (
    .clk       (clk),
    .rst       (rst),
    .sample_i  (s0_q),
    .level_i   (trig_level),
    .pulse_o   (ad_pulse),
    .outrange_o(outrange),
    .freq_o    (ad_freq),
    .max_o     (ad_max),
    .min_o     (ad_min),
    .vpp_o     (ad_vpp)
  );
endmodule

// File: tb/tb_dso_capture_core.sv
// Directed bench for dso_capture_core: read responses checked through a scoreboard
// queue, state and measurement outputs checked directly against hand-derived values.
module tb_dso_capture_core;
  import dso_pkg::*;

  localparam int GATE  = 5000;
  localparam int AUTO  = 500;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ad_data;
  logic        wave_run;
  logic [7:0]  trig_level;
  logic        trig_edge;
  logic [9:0]  h_shift;
  logic [9:0]  deci_rate;
  logic        ram_rd_en;
  logic        ram_rd_over;
  logic [9:0]  wave_rd_addr;
  logic [7:0]  wave_rd_data;
  logic        outrange;
  logic        ad_pulse;
  logic [19:0] ad_freq;
  logic [7:0]  ad_vpp;
  logic [7:0]  ad_max;
  logic [7:0]  ad_min;

  always #10 clk = ~clk;

  dso_capture_core #(
    .DEPTH      (DEPTH),
    .PRE_TRIG   (150),
    .GATE_CYCLES(GATE),
    .AUTO_TO    (AUTO),
    .HYST       (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ad_data     (ad_data),
    .wave_run    (wave_run),
    .trig_level  (trig_level),
    .trig_edge   (trig_edge),
    .h_shift     (h_shift),
    .deci_rate   (deci_rate),
    .ram_rd_en   (ram_rd_en),
    .ram_rd_over (ram_rd_over),
    .wave_rd_addr(wave_rd_addr),
    .wave_rd_data(wave_rd_data),
    .outrange    (outrange),
    .ad_pulse    (ad_pulse),
    .ad_freq     (ad_freq),
    .ad_vpp      (ad_vpp),
    .ad_max      (ad_max),
    .ad_min      (ad_min)
  );

  typedef struct {
    string name;
    int    exp;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   passed = 0;
  int   cyc = 0;
  int   mode = 0;  // 0 hold, 1 ramp, 2 sine

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, required %0d", name, act, exp);
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act >= lo && act <= hi) passed++;
    else $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
  endtask

  task automatic tick();
    real x;
    @(negedge clk);
    cyc++;
    if (mode == 1) begin
      ad_data = ad_data + 8'd1;
    end else if (mode == 2) begin
      x = 128.0 + 127.0 * $sin(2.0 * 3.14159265358979 * real'(cyc % 50) / 50.0);
      ad_data = 8'($rtoi(x + 0.5));
    end
  endtask

  task automatic rd(input string name, input int addr, input int exp);
    exp_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
    wave_rd_addr = 10'(addr);
    ram_rd_en    = 1'b1;
    tick();
    ram_rd_en = 1'b0;
  endtask

  task automatic wait_state(input string name, input state_e st, input int budget, output int n);
    n = 0;
    while (dut.state_q != st && n < budget) begin
      tick();
      n++;
    end
    chk(name, int'(dut.state_q), int'(st));
  endtask

  task automatic rd_over_pulse();
    ram_rd_over = 1'b1;
    tick();
    ram_rd_over = 1'b0;
  endtask

  // Monitor: a read issued at a posedge is compared at the following negedge.
  initial begin
    logic en_seen;
    exp_t e;
    forever begin
      @(posedge clk);
      en_seen = ram_rd_en;
      @(negedge clk);
      if (en_seen) begin
        if (sb_q.size() == 0) begin
          chk("unexpected read response", int'(wave_rd_data), -1);
        end else begin
          e = sb_q.pop_front();
          $display("read %s: data=%0d expected=%0d", e.name, wave_rd_data, e.exp);
          chk(e.name, int'(wave_rd_data), e.exp);
        end
      end
    end
  end

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal;
  end

  initial begin
    int n;
    rst = 1'b1; ad_data = 8'd0; wave_run = 1'b1; trig_level = 8'd128; trig_edge = 1'b0;
    h_shift = '0; deci_rate = 10'd1; ram_rd_en = 1'b0; ram_rd_over = 1'b0; wave_rd_addr = '0;
    repeat (5) tick();
    chk("reset wave_rd_data", int'(wave_rd_data), 0);
    chk("reset outrange", int'(outrange), 0);
    chk("reset ad_pulse", int'(ad_pulse), 0);
    chk("reset ad_freq", int'(ad_freq), 0);
    chk("reset ad_vpp", int'(ad_vpp), 0);
    chk("reset ad_max", int'(ad_max), 0);
    chk("reset ad_min", int'(ad_min), 0);

    rst = 1'b0;
    mode = 1;
    tick();
    chk("post-reset state", int'(dut.state_q), int'(PRE_FILL));
    repeat (3) tick();
    chk("post-reset wave_rd_data", int'(wave_rd_data), 0);

    // Ramp, decimation 1
    wait_state("deci1 reach DONE", DONE, 3000, n);
    rd("deci1 addr150", 150, 128);
    rd("deci1 addr149", 149, 127);
    rd("deci1 addr151", 151, 129);
    h_shift = 10'd2;
    rd("hshift2 addr148", 148, 128);
    h_shift = 10'd1023;
    rd("hshift1023 addr151", 151, 128);
    h_shift = 10'd0;
    tick();
    chk("read data hold", int'(wave_rd_data), 128);

    // Ramp restarted together with the switch to decimation 2
    deci_rate = 10'd2;
    ad_data = 8'd0;
    rd_over_pulse();
    chk("deci2 rearm state", int'(dut.state_q), int'(PRE_FILL));
    wait_state("deci2 reach DONE", DONE, 5000, n);
    rd("deci2 addr150", 150, 128);
    rd("deci2 addr149", 149, 126);
    rd("deci2 addr151", 151, 130);

    // Decimation 0 behaves as 1
    deci_rate = 10'd0;
    ad_data = 8'd0;
    rd_over_pulse();
    wait_state("deci0 reach DONE", DONE, 3000, n);
    rd("deci0 addr150", 150, 128);
    rd("deci0 addr149", 149, 127);
    rd("deci0 addr151", 151, 129);

    // Frozen record
    wave_run = 1'b0;
    repeat (3) begin
      rd_over_pulse();
      repeat (4) tick();
    end
    chk("freeze state", int'(dut.state_q), int'(DONE));
    rd("freeze addr150", 150, 128);
    rd("freeze addr149", 149, 127);

    // Constant input below level: auto trigger timeout
    wave_run = 1'b1;
    mode = 0;
    ad_data = 8'd50;
    deci_rate = 10'd1;
    rd_over_pulse();
    chk("auto rearm state", int'(dut.state_q), int'(PRE_FILL));
    wait_state("auto reach DONE", DONE, 3000, n);
    chk("auto kept samples to DONE", n, AUTO + DEPTH);
    rd("auto addr150", 150, 50);

    // 1 MHz sine at 50 MHz: 100 periods per window
    mode = 2;
    repeat (3 * GATE + 100) tick();
    chk_rng("sine ad_freq", int'(ad_freq), 99, 101);
    chk("sine ad_max", int'(ad_max), 255);
    chk("sine ad_min", int'(ad_min), 1);
    chk("sine ad_vpp", int'(ad_vpp), 254);
    chk("sine outrange", int'(outrange), 1);

    repeat (3) tick();
    chk("scoreboard pending entries", sb_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
